uart_rx_frame_unpacker: RTL

- **Role:** receive path of the plotter link, the counterpart of the edge-frame transmitter.
- **Input:** 8N1 UART stream of a bit-packed binary edge frame, FRAME_BYTES bytes per frame.
- **Output:** each byte expanded MSB-first into eight 8-bit pixels on a valid/ready stream with a linear pixel address.
- **Placement:** between the board RX pin and the frame RAM / path planner.

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_rx_core.sv | 106 ++++++++++
 rtl/uart_rx_frame_unpacker.sv | 120 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the plotter-link UART receive path
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} rx_state_t;

  localparam logic [7:0] PIX_EDGE = 8'hFF;
  localparam logic [7:0] PIX_BG   = 8'h00;

  function automatic int calc_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - 8N1 receiver: rx synchronizer, baud counter and RX FSM
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DIV = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  output logic [7:0] o_byte_data,
  output logic       o_byte_valid,
  output logic       o_frm_err,
  output logic       o_busy
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(DIV - 1);

  logic          r_rx_s1, r_rx_s2;
  rx_state_t     r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]    r_bit, w_bit_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          r_bv, w_bv_nxt;
  logic          r_fe, w_fe_nxt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_bv    <= 1'b0;
      r_fe    <= 1'b0;
    end else begin
      r_rx_s1 <= i_rx;
      r_rx_s2 <= r_rx_s1;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_bv    <= w_bv_nxt;
      r_fe    <= w_fe_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CW'(1);
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_bv_nxt    = 1'b0;
    w_fe_nxt    = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (!r_rx_s2) w_state_nxt = START;
      end
      START: begin
        // a start bit that is high again at mid-bit was a glitch
        if (r_cnt == HALF) begin
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
          w_state_nxt = r_rx_s2 ? IDLE : DATA;
        end
      end
      DATA: begin
        if (r_cnt == FULL) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {r_rx_s2, r_shift[7:1]};
          w_bit_nxt   = r_bit + 3'd1;
          if (r_bit == 3'd7) w_state_nxt = STOP;
        end
      end
      STOP: begin
        if (r_cnt == FULL) begin
          w_cnt_nxt = '0;
          if (r_rx_s2) begin
            w_bv_nxt    = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_fe_nxt    = 1'b1;
            w_state_nxt = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        w_cnt_nxt = '0;
        if (r_rx_s2) w_state_nxt = IDLE;
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign o_byte_data  = r_shift;
  assign o_byte_valid = r_bv;
  assign o_frm_err    = r_fe;
  assign o_busy       = (r_state != IDLE);

endmodule

// File: rtl/uart_rx_frame_unpacker.sv
// rtl/uart_rx_frame_unpacker.sv - expands received packed edge bytes into an addressed pixel stream
module uart_rx_frame_unpacker
  import uart_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int BAUD         = 115_200,
  parameter int FRAME_BYTES  = 5160,
  parameter int TIMEOUT_BITS = 32,
  localparam int AW          = $clog2(FRAME_BYTES * 8)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rx,
  input  logic          pix_ready,
  output logic          pix_valid,
  output logic [7:0]    pix_data,
  output logic [AW-1:0] pix_addr,
  output logic          frame_done,
  output logic          frame_err,
  output logic          overrun
);

  localparam int DIV = calc_div(CLK_HZ, BAUD);
  localparam logic [AW-1:0] LAST = AW'(FRAME_BYTES * 8 - 1);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_BITS * DIV - 1);

  logic [7:0] w_byte;
  logic       w_bv, w_frm_err, w_busy;

  uart_rx_core #(.DIV(DIV)) u_core (
    .i_clk        (clk),
    .i_rst_n      (reset),
    .i_rx         (rx),
    .o_byte_data  (w_byte),
    .o_byte_valid (w_bv),
    .o_frm_err    (w_frm_err),
    .o_busy       (w_busy)
  );

  logic [7:0]    r_sr, w_sr_nxt;
  logic [3:0]    r_sr_cnt, w_cnt_nxt;
  logic [7:0]    r_hr, w_hr_nxt;
  logic          r_hr_full, w_hrf_nxt;
  logic [AW-1:0] r_addr, w_addr_nxt;
  logic          r_overrun, w_ovr_nxt;
  logic [31:0]   r_tmo;
  logic          w_accept, w_active, w_tmo_run, w_timeout;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sr      <= '0;
      r_sr_cnt  <= '0;
      r_hr      <= '0;
      r_hr_full <= 1'b0;
      r_addr    <= '0;
      r_overrun <= 1'b0;
      r_tmo     <= '0;
    end else begin
      r_sr      <= w_sr_nxt;
      r_sr_cnt  <= w_cnt_nxt;
      r_hr      <= w_hr_nxt;
      r_hr_full <= w_hrf_nxt;
      r_addr    <= w_addr_nxt;
      r_overrun <= w_ovr_nxt;
      r_tmo     <= (w_tmo_run && !w_timeout) ? r_tmo + 32'd1 : 32'd0;
    end
  end

  assign w_accept  = pix_valid & pix_ready;
  assign w_active  = (r_addr != '0) || (r_sr_cnt != 4'd0) || r_hr_full;
  // line activity counts as progress, so a byte period longer than the timeout never aborts
  assign w_tmo_run = w_active && !w_busy && !w_bv;
  assign w_timeout = w_tmo_run && (r_tmo == TMO_LAST);

  always_comb begin
    w_sr_nxt   = r_sr;
    w_cnt_nxt  = r_sr_cnt;
    w_hr_nxt   = r_hr;
    w_hrf_nxt  = r_hr_full;
    w_addr_nxt = r_addr;
    w_ovr_nxt  = r_overrun;
    if (w_accept) begin
      w_sr_nxt   = {r_sr[6:0], 1'b0};
      w_cnt_nxt  = r_sr_cnt - 4'd1;
      w_addr_nxt = (r_addr == LAST) ? '0 : r_addr + AW'(1);
    end
    if (w_cnt_nxt == 4'd0) begin
      if (r_hr_full) begin
        w_sr_nxt  = r_hr;
        w_cnt_nxt = 4'd8;
        w_hrf_nxt = w_bv;
        if (w_bv) w_hr_nxt = w_byte;
      end else if (w_bv) begin
        w_sr_nxt  = w_byte;
        w_cnt_nxt = 4'd8;
      end
    end else if (w_bv) begin
      if (!r_hr_full) begin
        w_hr_nxt  = w_byte;
        w_hrf_nxt = 1'b1;
      end else begin
        w_ovr_nxt = 1'b1;
      end
    end
    if (w_timeout) begin
      w_sr_nxt   = '0;
      w_cnt_nxt  = 4'd0;
      w_hrf_nxt  = 1'b0;
      w_addr_nxt = '0;
    end
  end

  assign pix_valid  = (r_sr_cnt != 4'd0);
  assign pix_data   = r_sr[7] ? PIX_EDGE : PIX_BG;
  assign pix_addr   = r_addr;
  assign frame_done = w_accept && (r_addr == LAST);
  assign frame_err  = w_frm_err | w_timeout;
  assign overrun    = r_overrun;

endmodule
